// File: rtl/uart_tx_fifo_gen.sv
// UART transmitter with an integrated transmit FIFO.
// Frame: start bit, 5..DATA_WIDTH data bits LSB first, optional parity,
// then 1 or 2 stop bits; break holds the line low. The line advances only
// on baud_tick edges.
module uart_tx_fifo_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  baud_tick,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [3:0]            data_bits,
    input  logic [2:0]            parity_mode,
    input  logic                  stop2,
    input  logic                  send_break,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done,
    output logic                  full,
    output logic                  empty,
    output logic [FIFO_AW:0]      fifo_count,
    output logic                  overflow
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK} state_t;

    localparam logic [FIFO_AW:0]   CNT_ONE  = 1;
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;
    localparam logic [3:0]         BIT_ONE  = 1;
    localparam logic [3:0]         LEN_MAX  = 4'(DATA_WIDTH);

    // Out-of-range character lengths fall back to the maximum length.
    function automatic logic [3:0] clamp_len(input logic [3:0] db);
        if (db < 4'd5 || db > LEN_MAX)
            return LEN_MAX;
        return db;
    endfunction

    function automatic logic parity_on(input logic [2:0] mode);
        return (mode >= 3'd1) && (mode <= 3'd4);
    endfunction

    // Parity over the first len bits only; unknown modes behave as "none".
    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d,
                                        input logic [3:0] len,
                                        input logic [2:0] mode);
        logic x;
        x = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++)
            if (i < int'(len))
                x = x ^ d[i];
        case (mode)
            3'd1:    return ~x;
            3'd2:    return x;
            3'd3:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr, rd_ptr;
    logic [FIFO_AW:0]      count_q, count_next;
    logic                  full_q, empty_q, ovf_q;
    logic                  push, pop;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] shift_q, shift_next;
    logic [3:0]            cnt_q, cnt_next, len_q, len_next;
    logic [2:0]            pmode_q, pmode_next;
    logic                  stop2_q, stop2_next, par_q, par_next;
    logic                  tx_q, tx_next, busy_q, busy_next, done_q, done_next;
    logic                  launch;

    // A full FIFO still accepts a write when the FSM pops in the same cycle.
    assign push = wr_en && (!full_q || pop);

    // Next occupancy, used to register the full/empty flags.
    always_comb begin
        count_next = count_q;
        if (push && !pop)
            count_next = count_q + CNT_ONE;
        else if (pop && !push)
            count_next = count_q - CNT_ONE;
    end

    // FIFO storage carries data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    // FIFO pointers, occupancy, flags and the overflow pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            count_q <= count_next;
            full_q  <= (count_next == CNT_FULL);
            empty_q <= (count_next == '0);
            ovf_q   <= wr_en && full_q && !pop;
        end
    end

    // Transmit FSM registers; tx is registered so the line never glitches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            len_q   <= LEN_MAX;
            pmode_q <= '0;
            stop2_q <= 1'b0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            shift_q <= shift_next;
            cnt_q   <= cnt_next;
            len_q   <= len_next;
            pmode_q <= pmode_next;
            stop2_q <= stop2_next;
            par_q   <= par_next;
            tx_q    <= tx_next;
            busy_q  <= busy_next;
            done_q  <= done_next;
        end
    end

    // Next-state logic; the end of the last stop bit re-enters the IDLE decision
    // directly, so queued frames follow with exactly the configured stop bits.
    always_comb begin
        state_next = state;
        shift_next = shift_q;
        cnt_next   = cnt_q;
        len_next   = len_q;
        pmode_next = pmode_q;
        stop2_next = stop2_q;
        par_next   = par_q;
        tx_next    = tx_q;
        busy_next  = busy_q;
        done_next  = 1'b0;
        pop        = 1'b0;
        launch     = 1'b0;
        if (baud_tick) begin
            case (state)
                IDLE:   launch = 1'b1;
                START: begin
                    state_next = DATA;
                    tx_next    = shift_q[0];
                    shift_next = shift_q >> 1;
                    cnt_next   = BIT_ONE;
                end
                DATA: begin
                    if (cnt_q < len_q) begin
                        tx_next    = shift_q[0];
                        shift_next = shift_q >> 1;
                        cnt_next   = cnt_q + BIT_ONE;
                    end else if (parity_on(pmode_q)) begin
                        state_next = PARITY;
                        tx_next    = par_q;
                    end else begin
                        state_next = STOP1;
                        tx_next    = 1'b1;
                    end
                end
                PARITY: begin
                    state_next = STOP1;
                    tx_next    = 1'b1;
                end
                STOP1: begin
                    if (stop2_q) begin
                        state_next = STOP2;
                    end else begin
                        done_next = 1'b1;
                        launch    = 1'b1;
                    end
                end
                STOP2: begin
                    done_next = 1'b1;
                    launch    = 1'b1;
                end
                BREAK: begin
                    if (!send_break) begin
                        state_next = STOP1;
                        tx_next    = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
        if (launch) begin
            state_next = IDLE;
            tx_next    = 1'b1;
            busy_next  = 1'b0;
            len_next   = clamp_len(data_bits);
            pmode_next = parity_mode;
            stop2_next = stop2;
            if (send_break) begin
                state_next = BREAK;
                tx_next    = 1'b0;
                busy_next  = 1'b1;
            end else if (!empty_q) begin
                pop        = 1'b1;
                shift_next = mem[rd_ptr];
                par_next   = parity_bit(mem[rd_ptr], clamp_len(data_bits), parity_mode);
                state_next = START;
                tx_next    = 1'b0;
                busy_next  = 1'b1;
            end
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: doc/uart_tx_fifo_gen.md
Name: uart_tx_fifo_gen

Overview:
Parametrised asynchronous UART transmitter with an integrated transmit FIFO. It serialises words onto tx, advancing one bit per baud_tick strobe from the baud generator. Frame format is selectable at run time: 5..DATA_WIDTH data bits, five parity modes, 1 or 2 stop bits, and break generation. It is the successor to the fixed 7/8-bit transmitter in the CoreUARTapb family and sits between the APB register file and the tx pin.

Parameters:
DATA_WIDTH, 8, maximum character length; legal range 5..9.
FIFO_DEPTH, 16, FIFO entries; power of two, 2..256.
FIFO_AW, 4, log2(FIFO_DEPTH); must be consistent with FIFO_DEPTH.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
baud_tick  in  1  one-clk strobe per bit period
wr_en  in  1  push wr_data into the FIFO
wr_data  in  DATA_WIDTH  character; LSB is transmitted first
data_bits  in  4  character length; 5..DATA_WIDTH
parity_mode  in  3  000 none, 001 odd, 010 even, 011 mark, 100 space; others are treated as none
stop2  in  1  1 selects two stop bits
send_break  in  1  hold tx low while asserted
tx  out  1  serial output
busy  out  1  frame or break in progress
tx_done  out  1  one-clk pulse at the end of each frame
full  out  1  FIFO full
empty  out  1  FIFO empty
fifo_count  out  FIFO_AW+1  current number of FIFO entries
overflow  out  1  one-clk pulse when a write is dropped

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, asynchronous and active-low.
- Reset values: tx=1, busy=0, tx_done=0, full=0, empty=1, fifo_count=0, overflow=0, state IDLE. The FIFO is flushed.
- Reset asserted mid-frame forces tx=1 immediately (asynchronous), abandoning the frame.
- FIFO writes:
  - A write is accepted when wr_en=1 and either full=0 or a pop occurs in the same cycle.
  - wr_en=1 with full=1 and no pop drops the data and pulses overflow; fifo_count is unchanged.
- FIFO flags and pointers: full, empty and fifo_count are registered. There is no bypass path, so a word written in cycle N is visible to the FSM from N+1. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK. All transitions occur only on clk edges where baud_tick=1.
- IDLE:
  - If send_break=1: go to BREAK, tx<=0, busy<=1. Break has priority over FIFO data.
  - Else if empty=0: pop the FIFO head into the shift register and go to START with tx<=0, busy<=1.
  - At the same edge, latch data_bits, parity_mode and stop2. Changes to these inputs mid-frame have no effect.
  - data_bits outside 5..DATA_WIDTH is clamped to DATA_WIDTH.
- START: go to DATA; tx<=bit0; bit counter<=1.
- DATA:
  - If counter < latched length: tx<=bit[counter], counter++.
  - Else, if parity is enabled: go to PARITY and drive tx with the parity bit.
    - Odd: tx = ~XOR(data bits).
    - Even: tx = XOR(data bits).
    - Mark: tx = 1. Space: tx = 0.
  - Else: go to STOP1, tx<=1.
  - The XOR covers only the latched-length LSBs.
- PARITY: go to STOP1, tx<=1.
- STOP1: if stop2=1, go to STOP2. Otherwise go to IDLE, busy<=0, tx_done<=1.
- STOP2: go to IDLE, busy<=0, tx_done<=1.
- Back-to-back frames: if the FIFO is non-empty when STOP ends, the next START begins at the following baud_tick, giving exactly 1 or 2 stop periods.
- BREAK: tx stays 0. At the first baud_tick with send_break=0, go to STOP1 with tx<=1. This guarantees at least one mark period; stop2 is honoured.
- send_break asserted mid-frame is ignored until the frame returns to IDLE.
- Bit timing: each bit lasts exactly one baud_tick interval, and the start bit is full length. A frame is 1 + length + parity + stop bit periods.
- Every tx change occurs on a clk edge with baud_tick=1. tx is glitch-free (registered).

Test Plan:
- 8N1 with baud_tick every 4 clks; write 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1. Each bit lasts 4 clks. tx_done pulses once at the end; busy is low afterwards.
- data_bits=7, even parity, stop2=1; write 0x41 -> tx = 0, 1000001, parity 0, 1, 1. data_bits=5, odd parity, 0x1F -> parity bit 0.
- Mark and space parity with 0x00 -> parity bit 1 and 0 respectively. Changing parity_mode mid-frame leaves the frame intact; the next frame uses the new mode.
- With baud_tick held low, write 17 words at FIFO_DEPTH=16 -> full=1, fifo_count=16, overflow pulses on the 17th write. Then run 16 frames back-to-back with no gaps; data is transmitted in order.
- send_break held for 3 baud periods while idle -> tx low for 3 periods, then at least 1 high period before the next queued frame. Asserting send_break during DATA leaves that frame unaffected.
- Reset asserted during DATA -> tx=1 within the same clk, fifo_count=0, busy=0, and no tx_done pulse.
